display_bcd: RTL and testbench
==============================

# display_bcd

Downstream stage of the ALU's shift-add multiplier. It takes the 6-bit product, converts it to BCD with a sequential double-dabble FSM, and latches the digits into a display register. It then drives a time-multiplexed, common-anode 4-digit 7-segment display. The conversion is started by a one-cycle `init` handshake and reports completion on `done`.

## Interface
- `IN_W`, 6: width of the binary input.
- `N_DIG`, 2: BCD digits produced. Must be ≥ ceil(IN_W·log10 2).
- `AN_W`, 4: number of display anodes. Must be ≥ N_DIG.
- `DIV`, 50000: clock cycles per digit scan slot. Must be ≥ 1.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `init` in 1: start request. Sampled only in IDLE.
- `dato` in IN_W: unsigned binary value (multiplier product `pp`). Sampled together with `init`.
- `busy` out 1: high while a conversion is in progress.
- `done` out 1: one-cycle pulse when the display register is updated.
- `sseg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `an` out AN_W: digit enables, active-low, one-hot.

## Operation
- Converter FSM states: IDLE, ADJ, SHIFT, FIN.
  - IDLE: if `init`=1, load shift register {N_DIG·4 zeros, `dato`}, set bit counter = IN_W, assert `busy`, go to ADJ. Otherwise stay.
  - ADJ: each BCD nibble ≥ 5 gets +3. Go to SHIFT.
  - SHIFT: shift the whole register left by 1 and decrement the counter. If the counter reaches 0 go to FIN, else go to ADJ.
  - FIN: copy the BCD field to the display register, pulse `done`, clear `busy`, go to IDLE.
- `init` outside IDLE is ignored. `dato` is not re-sampled during a conversion.
- Nibble adjust is 4-bit modular: values 5–9 map to 8–12. Values > 9 cannot occur with legal input.
- Scan prescaler counts 0..DIV-1. On wrap, the digit index advances modulo AN_W (0 → 1 → … → AN_W-1 → 0).
- `an` = ~(1 << index). Digit 0 is the units digit.
- Index < N_DIG: `sseg` = 7-segment code of display digit[index]. Index ≥ N_DIG: `sseg` = 7'b1111111 (blank).
- The display register holds its value between conversions. Scanning runs continuously, independent of the FSM.
- `reset` (at any time, including mid-conversion) forces on the next edge:
  - FSM to IDLE, counters to 0, display register to 0;
  - `busy`=0, `done`=0 (no `done` pulse for the aborted conversion);
  - `an`=~1, `sseg`=7'b1000000.

## Timing
- Conversion latency: FSM in ADJ the cycle after `init` is sampled. ADJ/SHIFT alternate IN_W times (2·IN_W cycles). Then FIN.
- `done` is high for exactly one cycle, (2·IN_W+1) cycles after the `init` sampling edge: cycle 13 for IN_W=6.
- `busy` is high from the cycle after `init` sampling through the cycle before `done`. It is low while `done`=1.
- The display register updates on the edge that enters FIN. New digits show on `sseg` in the same cycle as `done` if the current scan slot selects a converted digit.
- Each scan slot lasts exactly DIV cycles. `an` and `sseg` change on the same edge. Outputs are registered.
- Back-to-back operation: `init`=1 during the `done` cycle is ignored. A new `init` is accepted the cycle after `done`.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: a display digit at index ≥1 shows blank (7'b1111111) when it and every higher converted digit are 0. Digit 0 is always shown.
- Not defined: all N_DIG converted digits are shown, including leading zeros.

## Structure
- Shared package: FSM state encoding, the 7-segment lookup constants for digits 0–9 and blank, and the reset `sseg` value.
- Sub-module `bin2bcd_dd` holds the converter FSM, shift register and `busy`/`done` logic, and outputs the BCD digits.
- `display_bcd` holds the display register, scan prescaler, anode rotation, segment decode and leading-zero blanking.

## Test plan
Bench settings: DIV=4, default widths.
- Reset held 2 cycles → `busy`=0, `done`=0, `an`=1110, `sseg`=1000000. Scanning then visits 1101, 1011, 0111 every 4 cycles with digits 0/blank.
- `dato`=63, `init` for 1 cycle → `busy`=1 for 12 cycles, `done` at cycle 13. Then `an`=1110 gives `sseg`=0110000 ("3") and `an`=1101 gives `sseg`=0000010 ("6").
- `dato`=9 → `an`=1110 gives 0010000. With `LEADING_ZERO_BLANK_EN`, `an`=1101 gives 1111111; without it, 1000000.
- Conversion of 63 with `init`=1 and `dato`=9 at cycle 5 → second request ignored, single `done`, display shows 63.
- `reset` at cycle 7 of a conversion of 45 → `busy`=0 next cycle, no `done` pulse, display shows 00.
- `dato`=0 → `done` at cycle 13, display shows 0 (tens per configuration).
- Back-to-back 17 then 42, second `init` one cycle after `done` → two `done` pulses 14 cycles apart, final display 42.

Source files
------------

// File: rtl/display_bcd_pkg.sv
// display_bcd_pkg: converter state encoding and 7-segment constants shared by display_bcd.
package display_bcd_pkg;
  typedef enum logic [1:0] {IDLE, ADJ, SHIFT, FIN} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_RST = 7'b1000000;
  // Active-low {g,f,e,d,c,b,a}, digit 9 in the top slice down to digit 0 in the bottom.
  localparam logic [69:0] SEG_TAB = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  function automatic logic [6:0] seg7(input logic [3:0] d);
    return d > 4'd9 ? SEG_BLANK : SEG_TAB[7*d +: 7];
  endfunction
endpackage

// File: rtl/display_bcd_bin2bcd_dd.sv
// bin2bcd_dd: sequential double-dabble binary to BCD converter with busy/done handshake.
module bin2bcd_dd
  import display_bcd_pkg::*;
#(
  parameter int IN_W = 6,
  parameter int N_DIG = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [IN_W-1:0]      dato,
  output logic                 busy,
  output logic                 done,
  output logic                 load,
  output logic [N_DIG*4-1:0]   bcd
);
  localparam int SW = N_DIG * 4 + IN_W;
  localparam int CW = $clog2(IN_W + 1);
  state_t state, nxt;
  logic [SW-1:0] sr, sr_adj;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE  ? (init ? ADJ : IDLE) :
          state == ADJ   ? SHIFT :
          state == SHIFT ? (cnt == CW'(1) ? FIN : ADJ) : IDLE;
  always_comb begin
    busy = state == ADJ || state == SHIFT;
    done = state == FIN;
    load = state == SHIFT && cnt == CW'(1);
    bcd = sr[SW-2 -: N_DIG*4];
  end
  always_comb begin
    sr_adj = sr;
    for (int j = 0; j < N_DIG; j++)
      if (sr[IN_W+4*j +: 4] >= 4'd5) sr_adj[IN_W+4*j +: 4] = sr[IN_W+4*j +: 4] + 4'd3;
  end
  always_ff @(posedge clk)
    if (reset) begin
      sr <= '0;
      cnt <= '0;
    end else if (state == IDLE && init) begin
      sr <= {{(N_DIG*4){1'b0}}, dato};
      cnt <= CW'(IN_W);
    end else if (state == ADJ) begin
      sr <= sr_adj;
    end else if (state == SHIFT) begin
      sr <= sr << 1;
      cnt <= cnt - CW'(1);
    end
endmodule

// File: rtl/display_bcd.sv
// display_bcd: BCD conversion plus multiplexed 7-segment display; LEADING_ZERO_BLANK_EN blanks leading zeros.
module display_bcd
  import display_bcd_pkg::*;
#(
  parameter int IN_W = 6,
  parameter int N_DIG = 2,
  parameter int AN_W = 4,
  parameter int DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [IN_W-1:0]   dato,
  output logic              busy,
  output logic              done,
  output logic [6:0]        sseg,
  output logic [AN_W-1:0]   an
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int IW = AN_W > 1 ? $clog2(AN_W) : 1;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  logic load, wrap, lz;
  logic [N_DIG*4-1:0] bcd, disp, disp_nxt;
  logic [PW-1:0] presc;
  logic [IW-1:0] idx, idx_nxt;
  logic [6:0] seg_nxt;
  bin2bcd_dd #(.IN_W(IN_W), .N_DIG(N_DIG)) u_conv (
    .clk(clk), .reset(reset), .init(init), .dato(dato),
    .busy(busy), .done(done), .load(load), .bcd(bcd)
  );
  // Decode from the incoming digits so fresh results appear in the done cycle.
  assign disp_nxt = load ? bcd : disp;
  assign wrap = presc == PW'(DIV - 1);
  assign idx_nxt = wrap ? (idx == IW'(AN_W - 1) ? '0 : idx + 1'b1) : idx;
  always_comb begin
    seg_nxt = SEG_BLANK;
    lz = 1'b1;
    for (int i = N_DIG - 1; i >= 0; i--) begin
      lz = lz && disp_nxt[4*i +: 4] == 4'd0;
      if (int'(idx_nxt) == i) seg_nxt = (LZB && i > 0 && lz) ? SEG_BLANK : seg7(disp_nxt[4*i +: 4]);
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      presc <= '0;
      idx <= '0;
      disp <= '0;
      an <= ~AN_W'(1);
      sseg <= SEG_RST;
    end else begin
      presc <= wrap ? '0 : presc + 1'b1;
      idx <= idx_nxt;
      disp <= disp_nxt;
      an <= ~(AN_W'(1) << idx_nxt);
      sseg <= seg_nxt;
    end
endmodule

// File: tb/tb_display_bcd.sv
// tb_display_bcd: randomized and directed checks of display_bcd against a cycle-level behavioural model.
module tb_display_bcd;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  logic clk, reset, init, busy, done;
  logic [5:0] dato;
  logic [6:0] sseg;
  logic [3:0] an;
  int checks, errors;
  int k, val, t, disp_m;
  bit armed;
  logic [6:0] segt [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  display_bcd #(.IN_W(6), .N_DIG(2), .AN_W(4), .DIV(4)) dut (
    .clk(clk), .reset(reset), .init(init), .dato(dato),
    .busy(busy), .done(done), .sseg(sseg), .an(an)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0b exp %0b", tag, t, got, exp);
    end
  endtask
  // k counts cycles since init was accepted: 1..12 busy, 13 done, 0 idle.
  task automatic step(input bit r, input bit i, input int d);
    int idx, exp;
    reset = r;
    init = i;
    dato = 6'(d);
    @(posedge clk);
    if (r) begin
      k = 0;
      disp_m = 0;
      t = 0;
      armed = 1;
    end else begin
      t++;
      if (k == 0) begin
        if (i) begin
          k = 1;
          val = d;
        end
      end else if (k == 13) k = 0;
      else begin
        k++;
        if (k == 13) disp_m = val;
      end
    end
    @(negedge clk);
    if (armed) begin
      idx = (t / 4) % 4;
      exp = idx == 0 ? int'(segt[disp_m % 10]) :
            idx == 1 ? ((LZB && disp_m < 10) ? 7'h7f : int'(segt[disp_m / 10])) : 7'h7f;
      check("busy", int'(busy), int'(k >= 1 && k <= 12));
      check("done", int'(done), int'(k == 13));
      check("an", int'(an), (~(1 << idx)) & 15);
      check("sseg", int'(sseg), exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, int'($urandom_range(63)));
  endtask
  initial begin
    checks = 0;
    errors = 0;
    armed = 0;
    k = 0;
    t = 0;
    disp_m = 0;
    val = 0;
    reset = 1'b1;
    init = 1'b0;
    dato = '0;
    step(1, 0, 0);
    step(1, 0, 0);
    idle(20);
    step(0, 1, 63);
    idle(30);
    step(0, 1, 9);
    idle(30);
    step(0, 1, 63);
    idle(3);
    step(0, 1, 9);
    idle(25);
    step(0, 1, 45);
    idle(5);
    step(1, 0, 0);
    idle(20);
    step(0, 1, 0);
    idle(30);
    step(0, 1, 17);
    repeat (13) step(0, 0, 0);
    step(0, 1, 42);
    idle(30);
    repeat (800) step($urandom_range(99) == 0, $urandom_range(5) == 0, int'($urandom_range(63)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
